// File: rtl/regfile_pkg.sv
// Shared widths and types for the multi-port register file.
package regfile_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = $clog2(NREGS);

    typedef logic [AW-1:0]   reg_addr_t;
    typedef logic [XLEN-1:0] xword_t;

endpackage

// File: rtl/reg_pending_table.sv
// Scoreboard of registers owned by in-flight multi-cycle producers.
// A bit is set when a producer is issued against the register and
// cleared when any write to that register lands.
module reg_pending_table
    import regfile_pkg::*;
#(
    parameter int NUM_WR   = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_WR-1:0]      wr_en,
    input  reg_addr_t [NUM_WR-1:0] wr_addr,
    input  logic                   claim_en,
    input  reg_addr_t              claim_addr,
    input  logic                   flush,
    output logic [NREGS-1:0]       pend_vec
);

    logic [NREGS-1:0] pend_nxt;

    // Next pending state: flush first, then write-back clears, then the
    // claim, so a new producer supersedes a write in the same cycle.
    always_comb begin
        pend_nxt = flush ? '0 : pend_vec;
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_en[i]) begin
                pend_nxt[wr_addr[i]] = 1'b0;
            end
        end
        if (claim_en && !(ZERO_REG && claim_addr == '0)) begin
            pend_nxt[claim_addr] = 1'b1;
        end
    end

    // Pending bit register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vec <= '0;
        end else begin
            pend_vec <= pend_nxt;
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write-first bypass and a
// per-register pending scoreboard for the decode stage.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  reg_addr_t [NUM_RD-1:0] rd_addr,
    output xword_t    [NUM_RD-1:0] rd_data,
    output logic      [NUM_RD-1:0] rd_ready,
    input  logic      [NUM_WR-1:0] wr_en,
    input  reg_addr_t [NUM_WR-1:0] wr_addr,
    input  xword_t    [NUM_WR-1:0] wr_data,
    input  logic                   claim_en,
    input  reg_addr_t              claim_addr,
    input  logic                   flush,
    output logic [NREGS-1:0]       pend_vec
);

    xword_t regs [NREGS];

    // Architectural storage; later ports are applied last so the
    // highest port index wins on an address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREGS; k++) begin
                regs[k] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_en[i] && !(ZERO_REG && wr_addr[i] == '0)) begin
                    regs[wr_addr[i]] <= wr_data[i];
                end
            end
        end
    end

    // Read ports: hardwired zero, then same-cycle bypass, then storage.
    // A matching write in flight also makes the operand ready now.
    always_comb begin
        for (int j = 0; j < NUM_RD; j++) begin
            rd_data[j]  = regs[rd_addr[j]];
            rd_ready[j] = !pend_vec[rd_addr[j]];
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_en[i] && wr_addr[i] == rd_addr[j]) begin
                    rd_data[j]  = wr_data[i];
                    rd_ready[j] = 1'b1;
                end
            end
            if (ZERO_REG && rd_addr[j] == '0) begin
                rd_data[j]  = '0;
                rd_ready[j] = 1'b1;
            end
        end
    end

    reg_pending_table #(
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_pend (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .flush      (flush),
        .pend_vec   (pend_vec)
    );

endmodule
